// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter that funnels N_MASTERS request/ack masters onto a single
// request/ack slave port. It handles one transaction at a time through the
// states IDLE -> ISSUE -> DONE, and every output comes from a register.
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to build an ISSUE-cycle counter.
// When the slave has not acked after TIMEOUT_CYCLES cycles, the transaction is
// aborted. The abort pulses m_ack with m_rdata = 32'hDEAD_BEEF and
// m_timeout = 1. Without the macro, ISSUE waits indefinitely and m_timeout is 0.
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      m_req,
    input  logic [N_MASTERS-1:0]      m_cmd,
    input  logic [32*N_MASTERS-1:0]   m_addr,
    input  logic [32*N_MASTERS-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]      m_ack,
    output logic [31:0]               m_rdata,
    output logic                      m_timeout,
    output logic                      s_req,
    output logic                      s_cmd,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    input  logic                      s_ack,
    input  logic [31:0]               s_rdata,
    output logic [2:0]                grant_id,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(N_MASTERS - 1);

    // One-hot ack vector for the given master index
    function automatic logic [N_MASTERS-1:0] idx_onehot(input logic [2:0] idx);
        logic [N_MASTERS-1:0] oh;
        oh = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (idx == 3'(j)) begin
                oh[j] = 1'b1;
            end else begin
                oh[j] = 1'b0;
            end
        end
        return oh;
    endfunction

    state_t               state_q, state_d;
    logic                 s_req_q, s_req_d;
    logic                 s_cmd_q, s_cmd_d;
    logic [31:0]          s_addr_q, s_addr_d;
    logic [31:0]          s_wdata_q, s_wdata_d;
    logic [N_MASTERS-1:0] m_ack_q, m_ack_d;
    logic [31:0]          m_rdata_q, m_rdata_d;
    logic [2:0]           grant_q, grant_d;
    logic [2:0]           last_grant_q, last_grant_d;
    logic                 busy_q, busy_d;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 m_timeout_q, m_timeout_d;
`else
    logic [31:0]          unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = 32'(TIMEOUT_CYCLES);
`endif

    // Arbitration results
    logic [7:0]           req_pad_s;
    logic [3:0]           cand_s;
    logic                 found_s;
    logic [2:0]           win_s;
    logic                 sel_cmd_s;
    logic [31:0]          sel_addr_s;
    logic [31:0]          sel_wdata_s;

    // Round-robin search, starting one past the last granted master
    always_comb begin
        req_pad_s                  = 8'b0;
        req_pad_s[N_MASTERS-1:0]   = m_req;
        found_s                    = 1'b0;
        win_s                      = 3'b0;
        cand_s                     = 4'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand_s = {1'b0, last_grant_q} + 4'(i);
            if (cand_s >= 4'(N_MASTERS)) begin
                cand_s = cand_s - 4'(N_MASTERS);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_pad_s[cand_s[2:0]]) begin
                found_s = 1'b1;
                win_s   = cand_s[2:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Select the winning master's command, address and write data
    always_comb begin
        sel_cmd_s   = 1'b0;
        sel_addr_s  = 32'h0000_0000;
        sel_wdata_s = 32'h0000_0000;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (win_s == 3'(j)) begin
                sel_cmd_s   = m_cmd[j];
                sel_addr_s  = m_addr[32*j +: 32];
                sel_wdata_s = m_wdata[32*j +: 32];
            end else begin
                sel_cmd_s   = sel_cmd_s;
            end
        end
    end

    // FSM next-state and registered-output next values
    always_comb begin
        state_d      = state_q;
        s_req_d      = s_req_q;
        s_cmd_d      = s_cmd_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        m_ack_d      = '0;
        m_rdata_d    = m_rdata_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        m_timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A stray s_ack here is ignored
                if (found_s) begin
                    state_d   = ST_ISSUE;
                    s_req_d   = 1'b1;
                    s_cmd_d   = sel_cmd_s;
                    s_addr_d  = sel_addr_s;
                    s_wdata_d = sel_wdata_s;
                    grant_d   = win_s;
                    busy_d    = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end else begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                end
            end
            ST_ISSUE: begin
                // The master dropping m_req does not abort the slave cycle
                if (s_ack) begin
                    state_d      = ST_DONE;
                    s_req_d      = 1'b0;
                    m_rdata_d    = s_rdata;
                    m_ack_d      = idx_onehot(grant_q);
                    last_grant_d = grant_q;
                    busy_d       = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = ST_DONE;
                    s_req_d      = 1'b0;
                    m_rdata_d    = 32'hDEAD_BEEF;
                    m_ack_d      = idx_onehot(grant_q);
                    m_timeout_d  = 1'b1;
                    last_grant_d = grant_q;
                    busy_d       = 1'b1;
                end else begin
                    state_d      = ST_ISSUE;
                    cnt_d        = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d      = ST_ISSUE;
                end
`endif
            end
            ST_DONE: begin
                // One-cycle gap: no arbitration, so the just-acked master is ignored
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                s_req_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            s_req_q      <= 1'b0;
            s_cmd_q      <= 1'b0;
            s_addr_q     <= 32'h0000_0000;
            s_wdata_q    <= 32'h0000_0000;
            m_ack_q      <= '0;
            m_rdata_q    <= 32'h0000_0000;
            grant_q      <= 3'b000;
            last_grant_q <= LAST_IDX;
            busy_q       <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            m_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s_req_q      <= s_req_d;
            s_cmd_q      <= s_cmd_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            m_ack_q      <= m_ack_d;
            m_rdata_q    <= m_rdata_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            m_timeout_q  <= m_timeout_d;
`endif
        end
    end

    assign s_req    = s_req_q;
    assign s_cmd    = s_cmd_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign m_ack    = m_ack_q;
    assign m_rdata  = m_rdata_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign m_timeout = m_timeout_q;
`else
    assign m_timeout = 1'b0;
`endif

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_MASTERS, 4, number of requesting masters (2..8) SHALL be supported.
REQ-002 Parameter TIMEOUT_CYCLES, 15, slave-ack wait limit (used only with timeout feature) SHALL be supported.
REQ-003 Port clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low.
REQ-005 Port m_req  in  N_MASTERS  per-master request, level, held until its m_ack.
REQ-006 Port m_cmd  in  N_MASTERS  per-master command, 0=read, 1=write.
REQ-007 Port m_addr  in  32*N_MASTERS  per-master address, master i in bits [32i+31:32i].
REQ-008 Port m_wdata  in  32*N_MASTERS  per-master write data, same packing.
REQ-009 Port m_ack  out  N_MASTERS  one-hot completion pulse to the granted master.
REQ-010 Port m_rdata  out  32  read data, valid in the m_ack cycle.
REQ-011 Port m_timeout  out  1  completion was a timeout abort.
REQ-012 Port s_req, s_cmd, s_addr[32], s_wdata[32]  out  slave request side.
REQ-013 Port s_ack  in  1, s_rdata  in  32  slave response side.
REQ-014 Port grant_id  out  3  index of the current/last granted master; busy  out  1  high outside IDLE.

Function
REQ-015 FSM SHALL have states IDLE, ISSUE, DONE; all outputs SHALL be registered.
REQ-016 IDLE: if any m_req is high, the arbiter SHALL pick a winner round-robin, starting the search at last_grant+1 (mod N_MASTERS), and enter ISSUE.
REQ-017 On that same edge, s_req SHALL go 1 and s_cmd/s_addr/s_wdata SHALL latch the winner's signals; latency m_req->s_req = 1 cycle.
REQ-018 ISSUE: s_req and latched cmd/addr/wdata SHALL be held stable until s_ack is sampled high.
REQ-019 On the edge sampling s_ack=1: s_req<=0, m_rdata<=s_rdata, m_ack[grant]<=1 (other bits 0), last_grant<=grant, state<=DONE.
REQ-020 DONE: m_ack SHALL clear after exactly one cycle; the granted master's m_req SHALL be ignored in this cycle; state SHALL return to IDLE.
REQ-021 Minimum request-to-request spacing SHALL therefore be 1 idle cycle; back-to-back requests from distinct masters SHALL be served in rotation.
REQ-022 last_grant SHALL wrap from N_MASTERS-1 to 0.
REQ-023 m_rdata SHALL hold its last value until the next completion; writes SHALL still load s_rdata (slave returns 0).
REQ-024 s_ack high while in IDLE or DONE SHALL be ignored.
REQ-025 m_req deassertion by the granted master during ISSUE SHALL NOT abort the slave transaction.

Reset
REQ-026 rst low SHALL immediately force state=IDLE, s_req=0, s_cmd=0, s_addr=0, s_wdata=0, m_ack=0, m_rdata=0, m_timeout=0, busy=0, grant_id=0, last_grant=N_MASTERS-1 (master 0 wins first).
REQ-027 Reset mid-ISSUE SHALL drop s_req without any m_ack pulse.

Configuration
REQ-028 Macro BUS_ARB_TIMEOUT_EN defined: an ISSUE cycle counter SHALL run; when TIMEOUT_CYCLES cycles pass without s_ack, the arbiter SHALL drop s_req, pulse m_ack[grant] with m_rdata=32'hDEAD_BEEF and m_timeout=1 for one cycle, and enter DONE.
REQ-029 Macro undefined: no counter is built, ISSUE SHALL wait indefinitely, m_timeout SHALL be tied 0.

Verification
REQ-030 Single read: m_req[0]=1, cmd=0, addr=0x10; slave acks 1 cycle after s_req with rdata=0x5 -> s_req high 1 cycle after m_req, m_ack=4'b0001 one cycle, m_rdata=0x5.
REQ-031 Contention: m_req=4'b1111 held continuously after reset -> grants in order 0,1,2,3,0, each m_ack one-hot.
REQ-032 Write passthrough: m_req[2]=1, cmd=1, addr=0xA0, wdata=0x1234 -> s_cmd=1, s_addr=0xA0, s_wdata=0x1234 stable until s_ack; m_ack=4'b0100.
REQ-033 Reset mid-ISSUE: rst low while s_req=1 -> s_req=0 asynchronously, no m_ack; after release m_req[1] alone is granted first-come.
REQ-034 With BUS_ARB_TIMEOUT_EN, slave never acks -> after 15 ISSUE cycles m_ack pulses, m_timeout=1, m_rdata=0xDEADBEEF, next master granted.
REQ-035 Stray s_ack=1 in IDLE -> no m_ack, state stays IDLE.
